// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and the arbitration rule for the cpu/loader memory port arbiter.
package mem_port_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE   = 2'd0;
  localparam arb_state_t ARB_ACCESS = 2'd1;
  localparam arb_state_t ARB_RESP   = 2'd2;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_EXT = 1'b1;

  localparam int DEFAULT_MEM_LATENCY  = 1;
  localparam int DEFAULT_STARVE_LIMIT = 4;

  // Loader wins when the cpu is halted, when it has starved long enough, or when alone.
  function automatic logic arb_pick_ext(input logic halted, input logic starved,
                                        input logic cpu_req, input logic ext_req);
    return ext_req & (halted | starved | ~cpu_req);
  endfunction

endpackage

// File: rtl/arb_aging_counter.sv
// Saturating count of consecutive arbitrations the loader lost to the cpu.
module arb_aging_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic starved
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CW'(STARVE_LIMIT))) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign starved = (count_q == CW'(STARVE_LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the cpu and the loader/debug port using a
// grant -> access -> response sequence per transfer.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE     = 16,
  parameter int MEM_ADDR_SIZE = 5,
  parameter int MEM_LATENCY   = DEFAULT_MEM_LATENCY,
  parameter int STARVE_LIMIT  = DEFAULT_STARVE_LIMIT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [MEM_ADDR_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0]     cpu_wdata,
  output logic                     cpu_ack,
  output logic [WORD_SIZE-1:0]     cpu_rdata,
  input  logic                     ext_req,
  input  logic                     ext_we,
  input  logic [MEM_ADDR_SIZE-1:0] ext_addr,
  input  logic [WORD_SIZE-1:0]     ext_wdata,
  output logic                     ext_ack,
  output logic [WORD_SIZE-1:0]     ext_rdata,
  input  logic                     cpu_halted,
  output logic [MEM_ADDR_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0]     mem_write_data,
  output logic                     mem_read,
  output logic                     mem_write,
  input  logic [WORD_SIZE-1:0]     mem_read_data,
  output logic                     busy
);

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  arb_state_t               state_q, state_d;
  logic                     owner_q, owner_d;
  logic                     we_q, we_d;
  logic [MEM_ADDR_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]     wdata_q, wdata_d;
  logic [WORD_SIZE-1:0]     rdata_q, rdata_d;
  logic [LAT_W-1:0]         lat_q, lat_d;

  logic starved;
  logic pick_ext;
  logic aging_clr;
  logic aging_inc;
  logic in_access;
  logic in_resp;

  arb_aging_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_aging (
    .clock   (clock),
    .reset   (reset),
    .clr     (aging_clr),
    .inc     (aging_inc),
    .starved (starved)
  );

  assign pick_ext = arb_pick_ext(cpu_halted, starved, cpu_req, ext_req);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    lat_d     = lat_q;
    aging_clr = 1'b0;
    aging_inc = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        // The aging counter only moves on IDLE cycles; it holds while a transfer runs.
        aging_clr = ~ext_req | pick_ext;
        aging_inc = ext_req & ~pick_ext;
        if (cpu_req || ext_req) begin
          owner_d = pick_ext ? OWNER_EXT : OWNER_CPU;
          we_d    = pick_ext ? ext_we    : cpu_we;
          addr_d  = pick_ext ? ext_addr  : cpu_addr;
          wdata_d = pick_ext ? ext_wdata : cpu_wdata;
          lat_d   = '0;
          state_d = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (lat_q == LAT_W'(MEM_LATENCY - 1)) begin
          rdata_d = we_q ? '0 : mem_read_data;
          state_d = ARB_RESP;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      owner_q <= OWNER_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      lat_q   <= lat_d;
    end
  end

  // Outputs decode straight from flops so an async reset silences them immediately.
  assign in_access      = (state_q == ARB_ACCESS);
  assign in_resp        = (state_q == ARB_RESP);
  assign mem_address    = in_access ? addr_q : '0;
  assign mem_write_data = in_access ? wdata_q : '0;
  assign mem_read       = in_access & ~we_q;
  assign mem_write      = in_access & we_q;
  assign cpu_ack        = in_resp & (owner_q == OWNER_CPU);
  assign ext_ack        = in_resp & (owner_q == OWNER_EXT);
  assign cpu_rdata      = cpu_ack ? rdata_q : '0;
  assign ext_rdata      = ext_ack ? rdata_q : '0;
  assign busy           = (state_q != ARB_IDLE);

endmodule
